// File: rtl/spi_slave.sv
// spi_slave: SPI slave endpoint, mirror of spi_master.
//   clk, rst_n           system clock, asynchronous active-low reset
//   sclk, mosi, ss       SPI lines from the master, oversampled via 2-flop synchronizers
//   miso, miso_oe        reply data and its output enable (high while selected)
//   tx_data, tx_load     reply word written into a single-entry buffer
//   tx_ready             tx buffer empty
//   rx_data, rx_valid    last received word / unread flag, consumed by rx_ack
//   rx_overrun           sticky: a word completed while rx_valid was high
//   frame_abort, irq     1-cycle pulses: ss dropped mid-word / word completed
//   busy                 synchronized ss active
// Handshake: tx_load is accepted only in a cycle where tx_ready=1 (buffer
// becomes full next cycle); rx_ack in any cycle clears rx_valid and rx_overrun
// on the next cycle, unless a word completes in that same cycle.
// The FSM state is held in state_q for checker binding.
module spi_slave #(
  parameter int MODE             = 3,
  parameter int DATA_WIDTH       = 32,
  parameter int SLAVE_ACTIVE_LOW = 1,
  parameter int MSB_FIRST        = 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX_VALUE = DATA_WIDTH'(32'hA5A5_A5A5)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  rx_overrun,
  output logic                  frame_abort,
  output logic                  busy,
  output logic                  irq
);

  localparam logic CPOL    = (MODE & 2) != 0;
  localparam logic CPHA    = (MODE & 1) != 0;
  localparam logic SS_IDLE = SLAVE_ACTIVE_LOW != 0;
  localparam int   CW      = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  state_t                state_q, state_d;
  logic                  sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic                  mosi_s1_q, mosi_s2_q;
  logic                  ss_s1_q, ss_s2_q;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  miso_q, miso_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_full_q, tx_full_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_overrun_q, rx_overrun_d;
  logic                  frame_abort_q, frame_abort_d;
  logic                  irq_q, irq_d;

  logic                  ss_active, sclk_edge, lead_edge, trail_edge;
  logic                  sample_edge, drive_edge;
  logic [DATA_WIDTH-1:0] rx_word, load_word;

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction

  assign ss_active   = (SLAVE_ACTIVE_LOW != 0) ? !ss_s2_q : ss_s2_q;
  assign sclk_edge   = sclk_s2_q != sclk_prev_q;
  assign lead_edge   = sclk_edge && (sclk_s2_q != CPOL);
  assign trail_edge  = sclk_edge && (sclk_s2_q == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge : trail_edge;
  assign rx_word     = shift_in(rx_sr_q, mosi_s2_q);
  assign load_word   = tx_full_q ? tx_buf_q : DEFAULT_TX_VALUE;

  always_comb begin
    state_d       = state_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    bit_cnt_d     = bit_cnt_q;
    miso_d        = miso_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = rx_overrun_q;
    frame_abort_d = 1'b0;
    irq_d         = 1'b0;

    if (tx_load && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
    if (rx_ack) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ss_active) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (tx_full_q) tx_full_d = 1'b0;
        bit_cnt_d = '0;
        if (!CPHA) begin
          miso_d  = out_bit(load_word);
          tx_sr_d = shift_out(load_word);
        end else begin
          tx_sr_d = load_word;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!ss_active) begin
          frame_abort_d = bit_cnt_q != '0;
          miso_d        = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          if (sample_edge) begin
            rx_sr_d   = rx_word;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q + 1'b1 == CW'(DATA_WIDTH)) begin
              irq_d   = 1'b1;
              state_d = ST_LOAD;
              // An ack in the same cycle frees the slot, so no overrun then.
              if (!rx_valid_q || rx_ack) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
              end else begin
                rx_overrun_d = 1'b1;
              end
            end
          end
          // CPHA=0 already put bit 0 out in LOAD; the trailing edge that
          // follows LOAD belongs to the previous word and must not shift.
          if (drive_edge && (CPHA || bit_cnt_q != '0)) begin
            miso_d  = out_bit(tx_sr_q);
            tx_sr_d = shift_out(tx_sr_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q     <= CPOL;
      sclk_s2_q     <= CPOL;
      sclk_prev_q   <= CPOL;
      mosi_s1_q     <= 1'b0;
      mosi_s2_q     <= 1'b0;
      ss_s1_q       <= SS_IDLE;
      ss_s2_q       <= SS_IDLE;
      state_q       <= ST_IDLE;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      sclk_s1_q     <= sclk;
      sclk_s2_q     <= sclk_s1_q;
      sclk_prev_q   <= sclk_s2_q;
      mosi_s1_q     <= mosi;
      mosi_s2_q     <= mosi_s1_q;
      ss_s1_q       <= ss;
      ss_s2_q       <= ss_s1_q;
      state_q       <= state_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      miso_q        <= miso_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      frame_abort_q <= frame_abort_d;
      irq_q         <= irq_d;
    end
  end

  assign busy        = state_q != ST_IDLE;
  assign miso_oe     = busy;
  assign miso        = miso_oe ? miso_q : 1'b0;
  assign tx_ready    = !tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign frame_abort = frame_abort_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave. Instance 0 is the 32-bit mode-3
// MSB-first slave; instances 1..6 are 8-bit slaves in modes 0/1/2 with
// LSB-first (1..3) and MSB-first (4..6). A bit-banged master drives each.
module tb_spi_slave;

  localparam int N = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int mode_a[N] = '{3, 0, 1, 2, 0, 1, 2};
  int msb_a[N]  = '{1, 0, 0, 0, 1, 1, 1};
  int w_a[N]    = '{32, 8, 8, 8, 8, 8, 8};

  logic        sclk_a[N], mosi_a[N], ss_a[N], tx_load_a[N], rx_ack_a[N];
  logic [31:0] tx_data_a[N], rx_data_a[N];
  logic        miso_a[N], miso_oe_a[N], tx_ready_a[N], rx_valid_a[N];
  logic        rx_overrun_a[N], frame_abort_a[N], busy_a[N], irq_a[N];

  spi_slave #(
    .MODE(3), .DATA_WIDTH(32), .SLAVE_ACTIVE_LOW(1), .MSB_FIRST(1),
    .DEFAULT_TX_VALUE(32'hA5A5_A5A5)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_a[0]), .mosi(mosi_a[0]), .ss(ss_a[0]),
    .miso(miso_a[0]), .miso_oe(miso_oe_a[0]), .tx_data(tx_data_a[0]),
    .tx_load(tx_load_a[0]), .tx_ready(tx_ready_a[0]), .rx_data(rx_data_a[0]),
    .rx_valid(rx_valid_a[0]), .rx_ack(rx_ack_a[0]), .rx_overrun(rx_overrun_a[0]),
    .frame_abort(frame_abort_a[0]), .busy(busy_a[0]), .irq(irq_a[0])
  );

  for (genvar g = 1; g < N; g++) begin : g_small
    logic [7:0] rxd;
    spi_slave #(
      .MODE((g - 1) % 3), .DATA_WIDTH(8), .SLAVE_ACTIVE_LOW(1),
      .MSB_FIRST((g - 1) / 3), .DEFAULT_TX_VALUE(8'hA5)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_a[g]), .mosi(mosi_a[g]), .ss(ss_a[g]),
      .miso(miso_a[g]), .miso_oe(miso_oe_a[g]), .tx_data(tx_data_a[g][7:0]),
      .tx_load(tx_load_a[g]), .tx_ready(tx_ready_a[g]), .rx_data(rxd),
      .rx_valid(rx_valid_a[g]), .rx_ack(rx_ack_a[g]), .rx_overrun(rx_overrun_a[g]),
      .frame_abort(frame_abort_a[g]), .busy(busy_a[g]), .irq(irq_a[g])
    );
    assign rx_data_a[g] = {24'h0, rxd};
  end

  // Pulse counters, sampled away from the active edge.
  int irq_cnt[N];
  int abort_cnt[N];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (irq_a[i] === 1'b1) irq_cnt[i] = irq_cnt[i] + 1;
      if (frame_abort_a[i] === 1'b1) abort_cnt[i] = abort_cnt[i] + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half();
    cycles(6);
  endtask

  task automatic load_tx(input int idx, input logic [31:0] val);
    @(negedge clk);
    tx_data_a[idx] = val;
    tx_load_a[idx] = 1'b1;
    @(negedge clk);
    tx_load_a[idx] = 1'b0;
  endtask

  task automatic ack_rx(input int idx);
    @(negedge clk);
    rx_ack_a[idx] = 1'b1;
    @(negedge clk);
    rx_ack_a[idx] = 1'b0;
    cycles(1);
  endtask

  // Shift the first n bits of a w-bit word; the master samples MISO on the
  // same edge the slave samples MOSI.
  task automatic spi_bits(input int idx, input int n, input logic [31:0] tx,
                          output logic [31:0] rx);
    logic cpol, cpha;
    int   b;
    cpol = (mode_a[idx] & 2) != 0;
    cpha = (mode_a[idx] & 1) != 0;
    rx = '0;
    for (int i = 0; i < n; i++) begin
      b = (msb_a[idx] != 0) ? (w_a[idx] - 1 - i) : i;
      if (!cpha) begin
        mosi_a[idx] = tx[b];
        half();
        rx[b] = miso_a[idx];
        sclk_a[idx] = ~cpol;
        half();
        sclk_a[idx] = cpol;
      end else begin
        half();
        sclk_a[idx] = ~cpol;
        mosi_a[idx] = tx[b];
        half();
        rx[b] = miso_a[idx];
        sclk_a[idx] = cpol;
      end
    end
  endtask

  task automatic ss_on(input int idx);
    ss_a[idx] = 1'b0;
    cycles(8);
  endtask

  task automatic ss_off(input int idx);
    half();
    ss_a[idx] = 1'b1;
    cycles(10);
  endtask

  task automatic frame(input int idx, input logic [31:0] tx, output logic [31:0] rx);
    ss_on(idx);
    spi_bits(idx, w_a[idx], tx, rx);
    ss_off(idx);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, " miso"},        {31'h0, miso_a[0]},        32'h0);
    check({pfx, " miso_oe"},     {31'h0, miso_oe_a[0]},     32'h0);
    check({pfx, " tx_ready"},    {31'h0, tx_ready_a[0]},    32'h1);
    check({pfx, " rx_data"},     rx_data_a[0],              32'h0);
    check({pfx, " rx_valid"},    {31'h0, rx_valid_a[0]},    32'h0);
    check({pfx, " rx_overrun"},  {31'h0, rx_overrun_a[0]},  32'h0);
    check({pfx, " frame_abort"}, {31'h0, frame_abort_a[0]}, 32'h0);
    check({pfx, " busy"},        {31'h0, busy_a[0]},        32'h0);
    check({pfx, " irq"},         {31'h0, irq_a[0]},         32'h0);
  endtask

  logic [31:0] mrx, mrx2;
  int          irq0, ab0;
  logic [7:0]  sm_tx[2] = '{8'h81, 8'hB2};
  logic [7:0]  sl_tx[2] = '{8'h3C, 8'h4D};

  initial begin
    for (int i = 0; i < N; i++) begin
      sclk_a[i]    = (mode_a[i] & 2) != 0;
      mosi_a[i]    = 1'b0;
      ss_a[i]      = 1'b1;
      tx_load_a[i] = 1'b0;
      rx_ack_a[i]  = 1'b0;
      tx_data_a[i] = '0;
      irq_cnt[i]   = 0;
      abort_cnt[i] = 0;
    end
    cycles(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cycles(3);

    // Loaded reply; a second load while full must be ignored.
    load_tx(0, 32'h1234_5678);
    check("tx_ready after load", {31'h0, tx_ready_a[0]}, 32'h0);
    load_tx(0, 32'hFFFF_FFFF);
    frame(0, 32'hDEAD_BEEF, mrx);
    check("master rx loaded", mrx, 32'h1234_5678);
    check("rx_data DEADBEEF", rx_data_a[0], 32'hDEAD_BEEF);
    check("rx_valid word1", {31'h0, rx_valid_a[0]}, 32'h1);
    check("irq count word1", irq_cnt[0], 1);
    check("tx_ready after LOAD", {31'h0, tx_ready_a[0]}, 32'h1);
    check("no overrun word1", {31'h0, rx_overrun_a[0]}, 32'h0);
    ack_rx(0);
    check("rx_valid cleared", {31'h0, rx_valid_a[0]}, 32'h0);

    // Empty buffer: default reply.
    frame(0, 32'h0000_0001, mrx);
    check("master rx default", mrx, 32'hA5A5_A5A5);
    check("rx_data 1", rx_data_a[0], 32'h0000_0001);
    ack_rx(0);

    // Two words in one selection without ack.
    irq0 = irq_cnt[0];
    ss_on(0);
    spi_bits(0, 32, 32'h1111_1111, mrx);
    spi_bits(0, 32, 32'h2222_2222, mrx2);
    ss_off(0);
    check("b2b rx_data", rx_data_a[0], 32'h1111_1111);
    check("b2b overrun", {31'h0, rx_overrun_a[0]}, 32'h1);
    check("b2b rx_valid", {31'h0, rx_valid_a[0]}, 32'h1);
    check("b2b irq pulses", irq_cnt[0] - irq0, 2);
    check("b2b master rx2", mrx2, 32'hA5A5_A5A5);
    check("b2b no abort", abort_cnt[0], 0);
    ack_rx(0);
    check("ack clears valid", {31'h0, rx_valid_a[0]}, 32'h0);
    check("ack clears overrun", {31'h0, rx_overrun_a[0]}, 32'h0);

    // Abort after 13 bits, then a clean frame.
    irq0 = irq_cnt[0];
    ss_on(0);
    spi_bits(0, 13, 32'hFFFF_FFFF, mrx);
    ss_off(0);
    check("abort pulse", abort_cnt[0], 1);
    check("abort rx_valid", {31'h0, rx_valid_a[0]}, 32'h0);
    check("abort no irq", irq_cnt[0] - irq0, 0);
    frame(0, 32'hCAFE_F00D, mrx);
    check("post-abort rx_data", rx_data_a[0], 32'hCAFE_F00D);
    ack_rx(0);

    // Reset in the middle of a word.
    ab0 = abort_cnt[0];
    ss_on(0);
    spi_bits(0, 10, 32'h5555_5555, mrx);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    cycles(2);
    ss_a[0]   = 1'b1;
    sclk_a[0] = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    check("midreset no abort", abort_cnt[0] - ab0, 0);
    frame(0, 32'h0F0F_0F0F, mrx);
    check("post-reset rx_data", rx_data_a[0], 32'h0F0F_0F0F);
    check("post-reset rx_valid", {31'h0, rx_valid_a[0]}, 32'h1);
    check("midreset still no abort", abort_cnt[0] - ab0, 0);

    // 8-bit sweep across modes and bit orders.
    for (int i = 1; i < N; i++) begin
      for (int v = 0; v < 2; v++) begin
        load_tx(i, {24'h0, sl_tx[v]});
        frame(i, {24'h0, sm_tx[v]}, mrx);
        check($sformatf("sweep%0d.%0d master rx", i, v), mrx, {24'h0, sl_tx[v]});
        check($sformatf("sweep%0d.%0d rx_data", i, v), rx_data_a[i], {24'h0, sm_tx[v]});
        check($sformatf("sweep%0d.%0d rx_valid", i, v), {31'h0, rx_valid_a[i]}, 32'h1);
        ack_rx(i);
      end
      check($sformatf("sweep%0d irq count", i), irq_cnt[i], 2);
      check($sformatf("sweep%0d abort count", i), abort_cnt[i], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave endpoint that sits directly downstream of the team's spi_master. It terminates the master's SCLK/MOSI/SS lines and drives MISO.
- All SPI inputs are oversampled in the system clock domain through 2-flop synchronizers.
- Received words are presented on a valid/ack interface.
- Reply words are accepted through a single-entry load/ready buffer.
- Mode, width, bit order and select polarity parameters match the master's, so a master/slave pair is configured identically.

Parameters:
MODE, 3, SPI mode 0-3 (CPOL = MODE[1], CPHA = MODE[0])
DATA_WIDTH, 32, word length in bits (>= 2)
SLAVE_ACTIVE_LOW, 1, 1: ss is active-low; 0: ss is active-high
MSB_FIRST, 1, 1: MSB shifted first on both MOSI and MISO; 0: LSB first
DEFAULT_TX_VALUE, 32'hA5A5_A5A5, word shifted out when the tx buffer is empty at word start

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock from master (asynchronous to clk)
mosi  in  1  master-out slave-in
ss  in  1  slave select (polarity per SLAVE_ACTIVE_LOW)
miso  out  1  slave-out master-in
miso_oe  out  1  MISO output enable; high while selected
tx_data  in  DATA_WIDTH  reply word
tx_load  in  1  write tx_data into the tx buffer
tx_ready  out  1  tx buffer empty
rx_data  out  DATA_WIDTH  last received word
rx_valid  out  1  rx_data holds an unread word
rx_ack  in  1  consume rx_data
rx_overrun  out  1  sticky: a word completed while rx_valid was high
frame_abort  out  1  1-cycle pulse: ss deasserted mid-word
busy  out  1  selected (synchronized ss active)
irq  out  1  1-cycle pulse per completed word

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, frame_abort=0, busy=0, irq=0.
  - Synchronizer flops reset to the idle levels: sclk=CPOL, ss=inactive.
  - Shift registers and bit counter reset to 0.
  - Reset mid-frame abandons the frame silently; frame_abort does not pulse.
- Timing constraint:
  - SCLK high and low phases are each >= 2 clk cycles (met by the master with CLOCK_DIVIDER >= 2).
  - ss setup to the first SCLK edge is >= 2 clk cycles.
- Edge detection: edges are detected on synchronized sclk (sync2 vs. previous sample).
  - Leading edge = transition away from CPOL.
  - Trailing edge = transition back to CPOL.
- States:
  - IDLE:
    - Transition: synchronized ss becomes active -> LOAD.
    - Outputs: busy=0, miso_oe=0.
  - LOAD (1 cycle):
    - Shift register <= tx buffer if full (buffer marked empty, tx_ready=1 next cycle), else DEFAULT_TX_VALUE.
    - Bit counter <= 0.
    - CPHA=0: first bit driven on miso now.
    - -> SHIFT.
  - SHIFT:
    - busy=1, miso_oe=1.
    - Sample MOSI on the leading edge (CPHA=0) or the trailing edge (CPHA=1).
    - Drive the next MISO bit on the opposite edge. For CPHA=1 the first bit is driven on the first leading edge.
    - Bit counter increments per sample.
    - When the counter reaches DATA_WIDTH, the word is complete:
      - If rx_valid=0: rx_data <= received word, rx_valid=1, irq pulses.
      - If rx_valid=1: word discarded, rx_overrun=1, irq still pulses.
      - -> LOAD (back-to-back words within one ss assertion).
    - ss deasserts: if bit counter != 0, pulse frame_abort and discard the partial word; then -> IDLE.
- tx buffer:
  - tx_load while tx_ready=1 captures tx_data; tx_ready drops the next cycle.
  - tx_load while tx_ready=0 is ignored, and the buffer is unchanged.
  - tx_load in the same cycle as LOAD consumes the buffer: the load is ignored because tx_ready is still 0 that cycle.
- rx handshake:
  - rx_ack clears rx_valid and rx_overrun the next cycle.
  - rx_ack in the same cycle as a word completion: the new word is captured, rx_valid stays 1, no overrun.
- Bit order: MSB_FIRST selects left shift (in at bit 0, out at MSB) or right shift (in at MSB, out at bit 0).
- miso is held 0 whenever miso_oe=0.

Test Plan:
- Mode 3, MSB first, tx buffer loaded with 0x1234_5678, master sends 0xDEAD_BEEF -> rx_data=0xDEADBEEF, rx_valid=1, irq one pulse, master receives 0x12345678, tx_ready=1 after LOAD.
- Empty tx buffer, master sends 0x0000_0001 -> master receives 0xA5A5A5A5; rx_data=0x00000001.
- Two words in one ss assertion (0x11111111 then 0x22222222) with no rx_ack -> rx_data=0x11111111, rx_overrun=1, two irq pulses; rx_ack clears both flags.
- ss deasserted after 13 bits -> frame_abort one pulse, rx_valid stays 0, next full frame 0xCAFEF00D received correctly.
- Sweep MODE 0/1/2 and MSB_FIRST=0, DATA_WIDTH=8, master sends 0x81, slave replies 0x3C -> both ends receive correctly in every combination.
- rst_n asserted mid-word -> all outputs return to reset values immediately, no frame_abort pulse, next frame 0x0F0F0F0F received correctly.
